// File: rtl/countdown_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// Digits are either decimal (0-9) or quaternary (0-3); the helpers
// below give each digit's largest legal value and clamp presets to it.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        EXPIRED
    } state_t;

    localparam logic [3:0] DIGIT_MAX_DEC  = 4'd9;
    localparam logic [3:0] DIGIT_MAX_QUAD = 4'd3;

    // Largest legal value of a digit: mode 0 is decimal, mode 1 is quaternary.
    function automatic logic [3:0] digit_max(input logic mode);
        return mode ? DIGIT_MAX_QUAD : DIGIT_MAX_DEC;
    endfunction

    // Saturate an out-of-range preset digit to its mode maximum.
    function automatic logic [3:0] clamp_digit(input logic mode, input logic [3:0] d);
        return (d > digit_max(mode)) ? digit_max(mode) : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One digit of the borrow-chained down counter.
// A load overrides everything; otherwise an incoming borrow decrements
// the digit, wrapping 0 to the mode maximum and passing the borrow on.
module bcd_down_digit
    import countdown_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       borrow_in,
    output logic [3:0] value,
    output logic       borrow_out
);

    logic [3:0] value_q;
    logic [3:0] value_d;

    // Next digit value: load first, then decrement-with-wrap on borrow.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_digit;
        end else if (borrow_in) begin
            value_d = (value_q == 4'd0) ? digit_max(mode) : value_q - 4'd1;
        end
    end

    // Digit storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value      = value_q;
    assign borrow_out = borrow_in && (value_q == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with pause/resume and expiry pulse.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN -- when defined, expiry
// reloads the count from the preset register and keeps running, unless
// the preset is zero, in which case the timer expires normally.
module bcd_countdown_timer
    import countdown_pkg::*;
#(
    parameter int                    NUM_DIGITS  = 4,
    parameter logic [NUM_DIGITS-1:0] DIGIT_MODES = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    start,
    input  logic                    pause,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    running,
    output logic                    done,
    output logic                    zero
);

    localparam int W = 4 * NUM_DIGITS;

    state_t              state_q;
    logic                running_q;
    logic                done_q;
    logic [W-1:0]        preset_q;
    logic [W-1:0]        clamped;
    logic [W-1:0]        digit_load_value;
    logic                digit_load;
    logic [NUM_DIGITS:0] borrow;
    logic                count_tick;
    logic                is_one;
    logic                expire;
    logic                reload;

    // Saturate every preset digit to the range its mode allows.
    always_comb begin
        clamped = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            clamped[4*i +: 4] = clamp_digit(DIGIT_MODES[i], load_value[4*i +: 4]);
        end
    end

    assign zero   = (value == '0);
    assign is_one = (value == W'(1));

    // A tick only counts in RUN when nothing of higher priority is present
    // and the count is non-zero, so the chain can never wrap below zero.
    assign count_tick = tick && (state_q == RUN) && !load && !pause && !zero;
    assign expire     = count_tick && is_one;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    assign reload = expire && (preset_q != '0);
`else
    assign reload = 1'b0;
`endif

    assign digit_load       = load || reload;
    assign digit_load_value = load ? clamped : preset_q;
    assign borrow[0]        = count_tick;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .mode       (DIGIT_MODES[g]),
            .load       (digit_load),
            .load_digit (digit_load_value[4*g +: 4]),
            .borrow_in  (borrow[g]),
            .value      (value[4*g +: 4]),
            .borrow_out (borrow[g+1])
        );
    end

    // Control FSM with registered running/done flags and the preset register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            preset_q  <= '0;
        end else begin
            done_q <= expire;
            if (load) begin
                preset_q  <= clamped;
                state_q   <= IDLE;
                running_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, PAUSED: begin
                        if (start && !pause && !zero) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state_q   <= PAUSED;
                            running_q <= 1'b0;
                        end else if (expire && !reload) begin
                            state_q   <= EXPIRED;
                            running_q <= 1'b0;
                        end
                    end
                    EXPIRED: begin
                        state_q   <= EXPIRED;
                        running_q <= 1'b0;
                    end
                    default: begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The most significant digit never borrows because ticks stop at zero.
    assert property (@(posedge clk) disable iff (reset) !borrow[NUM_DIGITS]);

    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: a table of directed vectors,
// hand-written multi-cycle sequences, and randomized stimulus against a
// mixed-radix integer model. Two DUTs share inputs: all-decimal and one
// with digit 1 quaternary. Honours COUNTDOWN_AUTO_RELOAD_EN when defined.
module tb_bcd_countdown_timer;

    localparam logic [3:0] MODES_D = 4'b0000;
    localparam logic [3:0] MODES_Q = 4'b0010;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    localparam int PH_IDLE    = 0;
    localparam int PH_RUN     = 1;
    localparam int PH_PAUSED  = 2;
    localparam int PH_EXPIRED = 3;

    logic        clk = 1'b0;
    logic        reset, tick, load, start, pause;
    logic [15:0] load_value;
    logic [15:0] valueD, valueQ;
    logic        runningD, runningQ, doneD, doneQ, zeroD, zeroQ;

    typedef struct {
        logic [15:0] value;
        logic [15:0] preset;
        int          phase;
        bit          done;
    } model_t;

    typedef struct {
        bit          r, l, s, p, t;
        logic [15:0] lv;
        logic [15:0] expValue;
        bit          expRunning;
        bit          expDone;
    } vec_t;

    model_t mD, mQ;
    vec_t   vecs[29];
    int     compared   = 0;
    int     mismatched = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    bcd_countdown_timer #(.NUM_DIGITS(4), .DIGIT_MODES(MODES_D)) dutD (
        .clk(clk), .reset(reset), .tick(tick), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .value(valueD), .running(runningD),
        .done(doneD), .zero(zeroD)
    );

    bcd_countdown_timer #(.NUM_DIGITS(4), .DIGIT_MODES(MODES_Q)) dutQ (
        .clk(clk), .reset(reset), .tick(tick), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .value(valueQ), .running(runningQ),
        .done(doneQ), .zero(zeroQ)
    );

    // Digits as a mixed-radix number, most significant digit first.
    function automatic int toCount(logic [15:0] v, logic [3:0] modes);
        int c = 0;
        for (int i = 3; i >= 0; i--) begin
            c = c * (modes[i] ? 4 : 10) + int'(v[4*i +: 4]);
        end
        return c;
    endfunction

    function automatic logic [15:0] fromCount(int c, logic [3:0] modes);
        logic [15:0] v = '0;
        int rem = c;
        for (int i = 0; i < 4; i++) begin
            int radix = modes[i] ? 4 : 10;
            v[4*i +: 4] = 4'(rem % radix);
            rem = rem / radix;
        end
        return v;
    endfunction

    function automatic logic [15:0] clampValue(logic [15:0] v, logic [3:0] modes);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            int mx = modes[i] ? 3 : 9;
            int d  = int'(v[4*i +: 4]);
            r[4*i +: 4] = 4'((d > mx) ? mx : d);
        end
        return r;
    endfunction

    function automatic model_t modelNext(model_t m, logic [3:0] modes,
                                         bit r, bit l, bit s, bit p, bit t,
                                         logic [15:0] lv);
        model_t n = m;
        int c;
        n.done = 1'b0;
        if (r) begin
            n.value  = '0;
            n.preset = '0;
            n.phase  = PH_IDLE;
        end else if (l) begin
            n.value  = clampValue(lv, modes);
            n.preset = n.value;
            n.phase  = PH_IDLE;
        end else if (m.phase == PH_RUN) begin
            c = toCount(m.value, modes);
            if (p) begin
                n.phase = PH_PAUSED;
            end else if (t && c > 0) begin
                c = c - 1;
                if (c == 0) begin
                    n.done = 1'b1;
                    if (AUTO_RELOAD && m.preset != 16'h0) begin
                        n.value = m.preset;
                    end else begin
                        n.value = '0;
                        n.phase = PH_EXPIRED;
                    end
                end else begin
                    n.value = fromCount(c, modes);
                end
            end
        end else if (m.phase == PH_IDLE || m.phase == PH_PAUSED) begin
            if (s && !p && m.value != 16'h0) n.phase = PH_RUN;
        end
        return n;
    endfunction

    task automatic checkVal(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("valueD",   valueD,          mD.value);
        checkVal("runningD", 16'(runningD),   16'(mD.phase == PH_RUN));
        checkVal("doneD",    16'(doneD),      16'(mD.done));
        checkVal("zeroD",    16'(zeroD),      16'(mD.value == 16'h0));
        checkVal("valueQ",   valueQ,          mQ.value);
        checkVal("runningQ", 16'(runningQ),   16'(mQ.phase == PH_RUN));
        checkVal("doneQ",    16'(doneQ),      16'(mQ.done));
        checkVal("zeroQ",    16'(zeroQ),      16'(mQ.value == 16'h0));
    endtask

    // Drive one cycle of inputs, advance both models at the edge, sample #1 later.
    task automatic applyStimulus(input bit r, input bit l, input bit s, input bit p,
                                 input bit t, input logic [15:0] lv);
        reset = r; load = l; start = s; pause = p; tick = t; load_value = lv;
        @(posedge clk);
        mD = modelNext(mD, MODES_D, r, l, s, p, t, lv);
        mQ = modelNext(mQ, MODES_Q, r, l, s, p, t, lv);
        #1;
    endtask

    initial begin
        bit seenDone;
        int ticks;
        reset = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
        load_value = '0;
        mD = '{16'h0, 16'h0, PH_IDLE, 1'b0};
        mQ = '{16'h0, 16'h0, PH_IDLE, 1'b0};

        //            r  l  s  p  t  load_val  expValue                       run              done
        vecs[0]  = '{1, 0, 0, 0, 0, 16'h0000, 16'h0000,                      0,               0};
        vecs[1]  = '{0, 1, 0, 0, 0, 16'h0003, 16'h0003,                      0,               0};
        vecs[2]  = '{0, 0, 1, 0, 0, 16'h0000, 16'h0003,                      1,               0};
        vecs[3]  = '{0, 0, 0, 0, 1, 16'h0000, 16'h0002,                      1,               0};
        vecs[4]  = '{0, 0, 0, 0, 1, 16'h0000, 16'h0001,                      1,               0};
        vecs[5]  = '{0, 0, 0, 0, 1, 16'h0000, AUTO_RELOAD ? 16'h3 : 16'h0,  AUTO_RELOAD,     1};
        vecs[6]  = '{0, 0, 0, 0, 1, 16'h0000, AUTO_RELOAD ? 16'h2 : 16'h0,  AUTO_RELOAD,     0};
        vecs[7]  = '{0, 0, 1, 0, 0, 16'h0000, AUTO_RELOAD ? 16'h2 : 16'h0,  AUTO_RELOAD,     0};
        vecs[8]  = '{0, 1, 0, 0, 0, 16'h0100, 16'h0100,                      0,               0};
        vecs[9]  = '{0, 0, 1, 0, 0, 16'h0000, 16'h0100,                      1,               0};
        vecs[10] = '{0, 0, 0, 0, 1, 16'h0000, 16'h0099,                      1,               0};
        vecs[11] = '{0, 1, 0, 0, 0, 16'hFFFF, 16'h9999,                      0,               0};
        vecs[12] = '{0, 1, 0, 0, 0, 16'h0000, 16'h0000,                      0,               0};
        vecs[13] = '{0, 0, 1, 0, 0, 16'h0000, 16'h0000,                      0,               0};
        vecs[14] = '{0, 1, 0, 0, 0, 16'h0005, 16'h0005,                      0,               0};
        vecs[15] = '{0, 0, 1, 0, 0, 16'h0000, 16'h0005,                      1,               0};
        vecs[16] = '{0, 0, 0, 1, 1, 16'h0000, 16'h0005,                      0,               0};
        vecs[17] = '{0, 0, 1, 0, 0, 16'h0000, 16'h0005,                      1,               0};
        vecs[18] = '{0, 0, 0, 0, 1, 16'h0000, 16'h0004,                      1,               0};
        vecs[19] = '{0, 1, 0, 0, 0, 16'h0002, 16'h0002,                      0,               0};
        vecs[20] = '{0, 0, 1, 0, 0, 16'h0000, 16'h0002,                      1,               0};
        vecs[21] = '{1, 0, 0, 0, 1, 16'h0000, 16'h0000,                      0,               0};
        vecs[22] = '{0, 1, 0, 0, 0, 16'h0007, 16'h0007,                      0,               0};
        vecs[23] = '{0, 0, 1, 0, 0, 16'h0000, 16'h0007,                      1,               0};
        vecs[24] = '{0, 1, 0, 0, 1, 16'h0003, 16'h0003,                      0,               0};
        vecs[25] = '{0, 0, 1, 1, 0, 16'h0000, 16'h0003,                      0,               0};
        vecs[26] = '{0, 0, 1, 0, 0, 16'h0000, 16'h0003,                      1,               0};
        vecs[27] = '{0, 0, 1, 1, 0, 16'h0000, 16'h0003,                      0,               0};
        vecs[28] = '{0, 0, 0, 0, 1, 16'h0000, 16'h0003,                      0,               0};

        $display("[TB] directed vectors");
        for (int i = 0; i < 29; i++) begin
            applyStimulus(vecs[i].r, vecs[i].l, vecs[i].s, vecs[i].p, vecs[i].t, vecs[i].lv);
            checkOutput();
            checkVal("vecValue",   valueD,        vecs[i].expValue);
            checkVal("vecRunning", 16'(runningD), 16'(vecs[i].expRunning));
            checkVal("vecDone",    16'(doneD),    16'(vecs[i].expDone));
            checkVal("vecZero",    16'(zeroD),    16'(vecs[i].expValue == 16'h0));
            if (i == 10) checkVal("quadBorrow", valueQ, 16'h0039);
            if (i == 11) checkVal("quadClamp",  valueQ, 16'h9939);
        end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        $display("[TB] auto-reload sequence");
        applyStimulus(0, 1, 0, 0, 0, 16'h0002);
        checkOutput();
        applyStimulus(0, 0, 1, 0, 0, 16'h0000);
        checkOutput();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 0, 1, 16'h0000);
            checkOutput();
            checkVal("reloadValue",   valueD,        (k % 2 == 0) ? 16'h0001 : 16'h0002);
            checkVal("reloadDone",    16'(doneD),    (k % 2 == 0) ? 16'h0 : 16'h1);
            checkVal("reloadRunning", 16'(runningD), 16'h1);
        end
`else
        $display("[TB] long expiry sequence");
        applyStimulus(0, 1, 0, 0, 0, 16'h1000);
        checkOutput();
        applyStimulus(0, 0, 1, 0, 0, 16'h0000);
        checkOutput();
        seenDone = 1'b0;
        ticks = 0;
        for (int k = 0; k < 1100 && !seenDone; k++) begin
            applyStimulus(0, 0, 0, 0, 1, 16'h0000);
            checkOutput();
            ticks++;
            if (doneD) seenDone = 1'b1;
        end
        checkVal("expiryTicks", 16'(ticks), 16'd1000);
        applyStimulus(0, 0, 1, 0, 1, 16'h0000);
        checkOutput();
        checkVal("expiredStartIgnored", 16'(runningD), 16'h0);
        checkVal("expiredHoldsZero",    valueD,        16'h0000);
`endif

        $display("[TB] random stimulus");
        for (int k = 0; k < 3000; k++) begin
            bit          r, l, s, p, t;
            logic [15:0] lv;
            r  = ($urandom_range(0, 99) == 0);
            l  = ($urandom_range(0, 11) == 0);
            s  = ($urandom_range(0, 3) == 0);
            p  = ($urandom_range(0, 9) == 0);
            t  = ($urandom_range(0, 3) != 0);
            lv = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h25));
            applyStimulus(r, l, s, p, t, lv);
            checkOutput();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Multi-digit BCD down-counter with borrow chaining. It is the decrementing counterpart of the up-counting carry-chain digit counters used in the timing datapath. It loads a preset, counts down one step per `tick` while running, pulses `done` when the count reaches zero, and supports pause/resume. Each digit is either decimal (0–9) or quaternary (0–3), chosen per digit at elaboration.

## Interface
- `NUM_DIGITS`, default 4: number of BCD digits (1–8).
- `DIGIT_MODES`, default `'0`: NUM_DIGITS-bit mask, one bit per digit; bit i = 0 gives digit i range 0–9, bit i = 1 gives range 0–3.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `tick`  in  1  count enable; one decrement per cycle in which it is high.
- `load`  in  1  load `load_value` into the count.
- `load_value`  in  4*NUM_DIGITS  preset; digit i is bits [4i+3:4i].
- `start`  in  1  begin or resume counting.
- `pause`  in  1  suspend counting.
- `value`  out  4*NUM_DIGITS  current count, registered.
- `running`  out  1  high in state RUN.
- `done`  out  1  one-cycle pulse on expiry.
- `zero`  out  1  combinational; high when every digit of `value` is 0.

## Operation
- FSM states: IDLE, RUN, PAUSED, EXPIRED.
- Reset: state IDLE, `value` 0, `done` 0, preset register 0. `running` is 0 and `zero` is 1.
- Input priority, highest first: `reset`, `load`, `start`/`pause`, `tick`.
- `load` (any state):
  - Each digit is clamped to its mode maximum. A digit above its max is stored as the max, e.g. 0xC becomes 9 in decimal mode and 3 in quaternary mode.
  - The clamped value is written to `value` and to the preset register.
  - State becomes IDLE. A `tick` in the same cycle is ignored.
- `start`:
  - IDLE→RUN and PAUSED→RUN, but only if `zero` is 0. If `zero` is 1, `start` is ignored.
  - In EXPIRED, `start` is ignored until `load`.
- `pause`: RUN→PAUSED. If `start` and `pause` are high together, `pause` wins.
- Borrow chain:
  - Digit 0 `borrow_in` = `tick` and state RUN.
  - A digit receiving `borrow_in` decrements. At 0 it wraps to its mode max and raises `borrow_out` (`borrow_in` and digit==0).
  - `borrow_out` of digit i is `borrow_in` of digit i+1.
- Expiry: a counting tick while `value` equals 1 (all upper digits 0, digit 0 = 1) sets `value` to 0, `done` to 1 for one cycle, and state to EXPIRED.
- `value` never wraps from 0 to all-max. With `zero` high, counting ticks have no effect.
- `tick` in IDLE, PAUSED or EXPIRED leaves `value` unchanged.

## Timing
- `value`, `running` and `done` update on the clock edge after the qualifying input; latency is 1 cycle.
- `start` at edge N means the first decrement can occur on a `tick` sampled at edge N+1.
- `tick` and `pause` in the same cycle: the pause takes effect, no decrement.
- `done` is high exactly one cycle, coincident with the first cycle `value` = 0 and `running` = 0.
- `reset` mid-count: `value` is 0 and state IDLE on the next edge. The preset register is cleared.
- `load` during RUN: the new value appears next cycle and `running` drops.

## Configuration
- Macro `COUNTDOWN_AUTO_RELOAD_EN`.
- Defined: on expiry, `done` pulses, `value` is reloaded from the preset register in the same edge instead of going to 0, and state stays RUN.
  - If the preset is 0, the block goes to EXPIRED as in the undefined case.
  - EXPIRED is then only reachable with a zero preset.
- Undefined: expiry behaviour as in Operation. No preset readback is needed, but the preset register is still kept so both builds share one datapath.

## Structure
- Package `countdown_pkg`:
  - `state_t` enum (IDLE, RUN, PAUSED, EXPIRED).
  - Constants `DIGIT_MAX_DEC` = 4'd9 and `DIGIT_MAX_QUAD` = 4'd3.
  - Function `digit_max(mode)`.
- Sub-module `bcd_down_digit`:
  - Ports: `clk`, `reset`, `mode`, `load`, `load_digit`, `borrow_in`, `value[3:0]`, `borrow_out`.
  - Instantiated NUM_DIGITS times in a generate loop.
- Top level holds the FSM, preset register, clamp logic and `done` register.

## Test plan
- Reset, then `load` 0x0003, `start`, `tick` every cycle → `value` 2, 1, 0. `done` high only with 0, state EXPIRED, `running` 0.
- `load` 0x0100, `start`, one `tick` → `value` 0x0099. With `DIGIT_MODES`=4'b0010, the same stimulus gives 0x0039.
- `load` 0xFFFF with default modes → `value` 0x9999. `start` with `load` 0x0000 → stays IDLE, no `done`.
- RUN at 0x0005, assert `pause` and `tick` together → `value` stays 5, state PAUSED. `start` resumes, next `tick` → 4.
- RUN at 0x0002, `reset` with `tick` → `value` 0, IDLE, no `done`. `load` with `tick` in RUN → `value` = loaded value, not decremented.
- `COUNTDOWN_AUTO_RELOAD_EN` defined: `load` 0x0002, `start`, `tick` ×4 → `value` 1, 2, 1, 2. `done` pulses on the 2nd and 4th ticks, `running` stays 1.
